// File: rtl/branch_seq.sv
// Branch sequencer: resolves a branch, waits for the delay slot,
// then issues a PC redirect to fetch.
module branch_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [3:0]  bf,
    input  logic        jmp,
    input  logic [31:0] br_target,
    input  logic        ops_ok,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        ds_fetched,
    input  logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack,
    output logic        busy,
    output logic [15:0] taken_cnt,
    output logic [15:0] ntaken_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPS,
        WAIT_DS,
        REDIRECT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_bf;
    logic        r_jmp;
    logic [31:0] r_target;
    logic        r_taken;
    logic        r_ds_seen;
    logic [15:0] r_taken_cnt;
    logic [15:0] r_ntaken_cnt;

    logic        w_hs;
    logic        w_eval;
    logic        w_cond;
    logic [3:0]  w_bf;
    logic        w_jmp;
    logic        w_ds_leave;
    logic        w_ds_set;

    function automatic logic f_cond(
        input logic [3:0]  f,
        input logic        j,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic lt;
        logic z;
        logic eq;
        lt = a[31];
        z  = (a == 32'd0);
        eq = (a == b);
        f_cond = 1'b0;
        if (j) begin
            f_cond = 1'b1;
        end else begin
            case (f[3:2])
                2'b00:   f_cond = f[1] & (f[0] ? !lt : lt);
                2'b10:   f_cond = f[1] ? !eq : eq;
                2'b11:   f_cond = f[1] ? !(lt | z) : (lt | z);
                default: f_cond = 1'b0;
            endcase
        end
    endfunction

    // flush masks the handshake so a flushed cycle never captures a branch
    assign br_ready       = (r_state == IDLE) && !flush;
    assign w_hs           = br_valid && br_ready;
    assign busy           = (r_state != IDLE);
    assign redirect_valid = (r_state == REDIRECT);
    assign redirect_pc    = redirect_valid ? r_target : 32'd0;
    assign taken_cnt      = r_taken_cnt;
    assign ntaken_cnt     = r_ntaken_cnt;

    // In IDLE the branch fields are still on the inputs, not yet captured
    assign w_bf   = (r_state == IDLE) ? bf  : r_bf;
    assign w_jmp  = (r_state == IDLE) ? jmp : r_jmp;
    assign w_cond = f_cond(w_bf, w_jmp, opa, opb);
    assign w_eval = !flush && ops_ok &&
                    ((r_state == IDLE && w_hs) || r_state == WAIT_OPS);

    assign w_ds_leave = (r_state == WAIT_DS) && (ds_fetched || r_ds_seen);
    assign w_ds_set   = ds_fetched &&
                        ((r_state == IDLE && w_hs) || r_state == WAIT_OPS);

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_hs) w_next = ops_ok ? WAIT_DS : WAIT_OPS;
                end
                WAIT_OPS: begin
                    if (ops_ok) w_next = WAIT_DS;
                end
                WAIT_DS: begin
                    if (w_ds_leave) w_next = r_taken ? REDIRECT : IDLE;
                end
                REDIRECT: begin
                    if (redirect_ack) w_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bf     <= 4'd0;
            r_jmp    <= 1'b0;
            r_target <= 32'd0;
            r_taken  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_bf     <= bf;
                r_jmp    <= jmp;
                r_target <= br_target;
            end
            if (w_eval) r_taken <= w_cond;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ds_seen <= 1'b0;
        end else if (flush || w_ds_leave) begin
            r_ds_seen <= 1'b0;
        end else if (w_ds_set) begin
            r_ds_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt  <= 16'd0;
            r_ntaken_cnt <= 16'd0;
        end else if (w_eval) begin
            if (w_cond) begin
                if (r_taken_cnt != 16'hFFFF)
                    r_taken_cnt <= r_taken_cnt + 16'd1;
            end else begin
                if (r_ntaken_cnt != 16'hFFFF)
                    r_ntaken_cnt <= r_ntaken_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_seq.sv
// Scoreboard bench for branch_seq: random branches against a
// rule-level model, plus flush, reset and saturation scenarios.
module tb_branch_seq;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  bf;
    logic        jmp;
    logic [31:0] br_target;
    logic        ops_ok;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        ds_fetched;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic        busy;
    logic [15:0] taken_cnt;
    logic [15:0] ntaken_cnt;

    branch_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .bf             (bf),
        .jmp            (jmp),
        .br_target      (br_target),
        .ops_ok         (ops_ok),
        .opa            (opa),
        .opb            (opb),
        .ds_fetched     (ds_fetched),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ack   (redirect_ack),
        .busy           (busy),
        .taken_cnt      (taken_cnt),
        .ntaken_cnt     (ntaken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          taken;
        logic [31:0] pc;
        int          tcnt;
        int          ncnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_tcnt = 0;
    int   m_ncnt = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Branch outcome straight from the ISA meaning of each code
    function automatic bit ref_taken(input logic [3:0] f, input bit j,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (j) return 1'b1;
        case (f[3:2])
            2'b00: begin
                if (!f[1]) return 1'b0;
                return f[0] ? ($signed(a) >= 0) : ($signed(a) < 0);
            end
            2'b10: return f[1] ? (a != b) : (a == b);
            2'b11: return f[1] ? ($signed(a) > 0) : ($signed(a) <= 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] f, input bit j,
                         input logic [31:0] tgt, input logic [31:0] a,
                         input logic [31:0] b, input int ops_delay,
                         input bit ds_early, input int ds_delay,
                         input int ack_delay);
        exp_t e;
        bit   tk;
        tk = ref_taken(f, j, a, b);
        if (tk) m_tcnt = sat(m_tcnt);
        else    m_ncnt = sat(m_ncnt);
        e.taken = tk;
        e.pc    = tgt;
        e.tcnt  = m_tcnt;
        e.ncnt  = m_ncnt;
        q.push_back(e);
        br_valid  = 1'b1;
        bf        = f;
        jmp       = j;
        br_target = tgt;
        if (ops_delay == 0) begin
            ops_ok = 1'b1;
            opa    = a;
            opb    = b;
        end else begin
            ops_ok = 1'b0;
            opa    = $urandom;
            opb    = $urandom;
        end
        tick();
        br_valid  = 1'b0;
        bf        = 4'($urandom);
        jmp       = 1'($urandom);
        br_target = $urandom;
        ops_ok    = 1'b0;
        opa       = $urandom;
        opb       = $urandom;
        for (int k = 0; k < ops_delay; k++) begin
            chk("busy_wait_ops", 32'(busy), 32'd1);
            ds_fetched = ds_early && (k == 0);
            tick();
        end
        ds_fetched = 1'b0;
        if (ops_delay > 0) begin
            ops_ok = 1'b1;
            opa    = a;
            opb    = b;
            tick();
            ops_ok = 1'b0;
            opa    = $urandom;
            opb    = $urandom;
        end
        if (ds_early && ops_delay > 0) begin
            tick();
        end else begin
            for (int k = 0; k < ds_delay; k++) tick();
            ds_fetched = 1'b1;
            tick();
            ds_fetched = 1'b0;
        end
        if (tk) begin
            chk("redir_valid", 32'(redirect_valid), 32'd1);
            chk("redir_pc", redirect_pc, tgt);
            for (int k = 0; k < ack_delay; k++) begin
                tick();
                chk("redir_hold_valid", 32'(redirect_valid), 32'd1);
                chk("redir_hold_pc", redirect_pc, tgt);
            end
            redirect_ack = 1'b1;
            tick();
            redirect_ack = 1'b0;
        end
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(br_ready), 32'd1);
        chk("end_redir", 32'(redirect_valid), 32'd0);
    endtask

    // Monitor: pops one expectation each time the block returns to IDLE
    initial begin
        bit          prev_busy;
        bit          seen;
        logic [31:0] seen_pc;
        exp_t        e;
        prev_busy = 1'b0;
        seen      = 1'b0;
        seen_pc   = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                seen      = 1'b0;
            end else begin
                if (redirect_valid) begin
                    if (!seen) begin
                        seen    = 1'b1;
                        seen_pc = redirect_pc;
                    end else if (mon_en) begin
                        chk("mon_pc_stable", redirect_pc, seen_pc);
                    end
                end
                if (prev_busy && !busy) begin
                    if (mon_en) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL mon_unexpected: got completion, expected none");
                        end else begin
                            e = q.pop_front();
                            chk("mon_taken", 32'(seen), 32'(e.taken));
                            if (e.taken) chk("mon_pc", seen_pc, e.pc);
                            chk("mon_tcnt", 32'(taken_cnt), 32'(e.tcnt));
                            chk("mon_ncnt", 32'(ntaken_cnt), 32'(e.ncnt));
                            chk("mon_idle_pc", redirect_pc, 32'd0);
                        end
                    end
                    seen = 1'b0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst_n        = 1'b1;
        br_valid     = 1'b0;
        bf           = 4'd0;
        jmp          = 1'b0;
        br_target    = 32'd0;
        ops_ok       = 1'b0;
        opa          = 32'd0;
        opb          = 32'd0;
        ds_fetched   = 1'b0;
        flush        = 1'b0;
        redirect_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(redirect_valid), 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_tcnt", 32'(taken_cnt), 32'd0);
        chk("rst_ncnt", 32'(ntaken_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        issue(4'b1000, 1'b0, 32'h400, 32'h5, 32'h5, 0, 1'b0, 0, 2);
        issue(4'b1110, 1'b0, 32'h800, 32'h0, 32'h3, 0, 1'b0, 0, 0);
        issue(4'b0010, 1'b0, 32'hC00, 32'h8000_0000, 32'h0, 0, 1'b0, 0, 0);
        issue(4'b1010, 1'b0, 32'h1000, 32'h1, 32'h2, 3, 1'b1, 0, 0);
        issue(4'b0100, 1'b1, 32'h2000, 32'h7, 32'h9, 0, 1'b0, 1, 5);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'd0;
                1:       a = 32'h8000_0000 | $urandom;
                2:       a = 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 1) == 1) ? a : 32'($urandom_range(0, 3));
            issue(4'($urandom), ($urandom_range(0, 7) == 0), $urandom,
                  a, b, $urandom_range(0, 3), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 3));
        end
        tick();
        tick();
        mon_en = 1'b0;

        // flush in WAIT_DS: evaluation already counted, no redirect
        br_valid = 1'b1; jmp = 1'b1; br_target = 32'h1234; ops_ok = 1'b1;
        tick();
        m_tcnt = sat(m_tcnt);
        br_valid = 1'b0; ops_ok = 1'b0;
        chk("fl_ds_busy_pre", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_ds_busy", 32'(busy), 32'd0);
        chk("fl_ds_valid", 32'(redirect_valid), 32'd0);
        chk("fl_ds_tcnt", 32'(taken_cnt), 32'(m_tcnt));
        ds_fetched = 1'b1;
        tick();
        ds_fetched = 1'b0;
        tick();
        chk("fl_ds_after", 32'(busy), 32'd0);

        // flush in REDIRECT
        br_valid = 1'b1; jmp = 1'b1; br_target = 32'h5678; ops_ok = 1'b1;
        tick();
        m_tcnt = sat(m_tcnt);
        br_valid = 1'b0; ops_ok = 1'b0; ds_fetched = 1'b1;
        tick();
        ds_fetched = 1'b0;
        chk("fl_rd_pre", 32'(redirect_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_rd_valid", 32'(redirect_valid), 32'd0);
        chk("fl_rd_pc", redirect_pc, 32'd0);
        chk("fl_rd_busy", 32'(busy), 32'd0);

        // evaluation aborted in WAIT_OPS and at handshake: not counted
        br_valid = 1'b1; jmp = 1'b1; ops_ok = 1'b0;
        tick();
        br_valid = 1'b0; ops_ok = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; ops_ok = 1'b0;
        chk("fl_ops_busy", 32'(busy), 32'd0);
        br_valid = 1'b1; ops_ok = 1'b1; flush = 1'b1;
        tick();
        br_valid = 1'b0; ops_ok = 1'b0; flush = 1'b0;
        chk("fl_hs_busy", 32'(busy), 32'd0);
        chk("fl_tcnt", 32'(taken_cnt), 32'(m_tcnt));
        chk("fl_ncnt", 32'(ntaken_cnt), 32'(m_ncnt));

        // flush must also discard a remembered delay-slot pulse
        br_valid = 1'b1; jmp = 1'b0; bf = 4'b0000; ops_ok = 1'b0;
        tick();
        br_valid = 1'b0; ds_fetched = 1'b1;
        tick();
        ds_fetched = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        br_valid = 1'b1; jmp = 1'b1; br_target = 32'hABC0; ops_ok = 1'b1;
        tick();
        m_tcnt = sat(m_tcnt);
        br_valid = 1'b0; ops_ok = 1'b0;
        tick();
        chk("fl_dsseen_busy", 32'(busy), 32'd1);
        chk("fl_dsseen_valid", 32'(redirect_valid), 32'd0);
        ds_fetched = 1'b1;
        tick();
        ds_fetched = 1'b0;
        chk("fl_dsseen_redir", 32'(redirect_valid), 32'd1);
        chk("fl_dsseen_pc", redirect_pc, 32'hABC0);
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        chk("fl_dsseen_idle", 32'(busy), 32'd0);
        chk("fl_end_tcnt", 32'(taken_cnt), 32'(m_tcnt));

        // asynchronous reset in REDIRECT
        br_valid = 1'b1; jmp = 1'b1; br_target = 32'h9ABC; ops_ok = 1'b1;
        tick();
        br_valid = 1'b0; ops_ok = 1'b0; ds_fetched = 1'b1;
        tick();
        ds_fetched = 1'b0;
        chk("ar_pre", 32'(redirect_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(redirect_valid), 32'd0);
        chk("ar_pc", redirect_pc, 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ready", 32'(br_ready), 32'd1);
        chk("ar_tcnt", 32'(taken_cnt), 32'd0);
        chk("ar_ncnt", 32'(ntaken_cnt), 32'd0);
        m_tcnt = 0;
        m_ncnt = 0;
        tick();
        #2 rst_n = 1'b1;
        redirect_ack = 1'b1;
        tick();
        tick();
        redirect_ack = 1'b0;
        chk("ar_after_valid", 32'(redirect_valid), 32'd0);
        chk("ar_after_busy", 32'(busy), 32'd0);

        // 0x10000 taken branches: counter sticks at 0xFFFF
        mon_en = 1'b1;
        for (int i = 0; i < 65536; i++)
            issue(4'b0000, 1'b1, $urandom, 32'd0, 32'd0, 0, 1'b0, 0, 0);
        tick();
        tick();
        chk("sat_tcnt", 32'(taken_cnt), 32'h0000_FFFF);
        chk("sat_ncnt", 32'(ntaken_cnt), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have one clock `clk` and an asynchronous, active-low reset `rst_n`; there are no other clocks or resets.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  decode presents a branch
- br_ready  out  1  block can accept a branch
- bf  in  4  branch function code
- jmp  in  1  unconditional jump; ignores bf
- br_target  in  32  branch target address
- ops_ok  in  1  opa/opb are valid (forwarding resolved)
- opa, opb  in  32 each  compare operands
- ds_fetched  in  1  one-cycle pulse: delay-slot instruction fetched
- flush  in  1  synchronous abort (exception)
- redirect_valid  out  1  PC redirect request
- redirect_pc  out  32  redirect address
- redirect_ack  in  1  fetch accepts the redirect
- busy  out  1  state != IDLE
- taken_cnt, ntaken_cnt  out  16 each  saturating statistics counters

Function
REQ-003 SHALL implement a four-state FSM: IDLE, WAIT_OPS, WAIT_DS, REDIRECT.
REQ-004 br_ready SHALL be 1 only in IDLE; a handshake occurs when br_valid && br_ready at a rising edge.
REQ-005 On handshake SHALL capture bf, jmp and br_target. If ops_ok is 1 in the same cycle, SHALL evaluate and go to WAIT_DS; otherwise SHALL go to WAIT_OPS.
REQ-006 In WAIT_OPS SHALL sample opa/opb on the first edge with ops_ok=1, evaluate, and go to WAIT_DS.
REQ-007 Condition evaluation (lt=opa[31], z=(opa==0), eq=(opa==opb)) SHALL be:
- bf=00_0x: not taken
- bf=00_10: lt (bltz)
- bf=00_11: !lt (bgez)
- bf=10_0x: eq (beq)
- bf=10_1x: !eq (bne)
- bf=11_0x: lt|z (blez)
- bf=11_1x: !(lt|z) (bgtz)
- bf=01_xx: not taken
- jmp=1: taken, regardless of bf
REQ-008 The taken result SHALL be registered at evaluation; taken_cnt or ntaken_cnt SHALL increment by 1 on that same edge, saturating at 0xFFFF.
REQ-009 A ds_fetched pulse arriving in IDLE (after the handshake edge) or in WAIT_OPS SHALL set an internal ds_seen flag so the pulse is not lost.
REQ-010 WAIT_DS SHALL be left on the first edge where ds_fetched=1 or ds_seen=1: to REDIRECT if taken, otherwise to IDLE; ds_seen SHALL clear on leaving WAIT_DS.
REQ-011 In REDIRECT, redirect_valid SHALL be 1 and redirect_pc SHALL equal the captured br_target, both held stable until redirect_ack=1, then the FSM SHALL go to IDLE.
REQ-012 Outside REDIRECT, redirect_valid SHALL be 0 and redirect_pc SHALL be 0.
REQ-013 Minimum latency, with ops_ok=1 and ds_fetched on the next cycle: handshake edge N, redirect_valid high after edge N+1.
REQ-014 flush=1 SHALL force IDLE on the next edge from any state, clear ds_seen and drop any pending redirect; flush has priority over every other input, and br_valid during flush SHALL not handshake.
REQ-015 The counters SHALL NOT count an evaluation that is aborted by flush in the same cycle.
REQ-016 busy SHALL equal (state != IDLE).

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- state to IDLE, ds_seen=0, captured registers=0
- redirect_valid=0, redirect_pc=0, busy=0
- taken_cnt=0, ntaken_cnt=0, br_ready=1
REQ-018 Reset asserted mid-operation (any state) SHALL discard the branch with no redirect issued after release.

Verification
REQ-019 beq: bf=1000, opa=opb=0x5, target=0x400, ops_ok=1, ds_fetched next cycle -> redirect_valid=1, redirect_pc=0x400 until ack; taken_cnt=1.
REQ-020 bgtz: bf=1110, opa=0x0 -> not taken; IDLE after ds_fetched, no redirect; ntaken_cnt=1. Repeat with opa=0x80000000 (bltz, bf=0010) -> taken.
REQ-021 ops_ok=0 for 3 cycles with ds_fetched pulsed during WAIT_OPS -> busy held; bne (bf=1010, opa=1, opb=2) is evaluated when ops_ok rises; redirect follows without a further ds_fetched.
REQ-022 Hold redirect_ack=0 for 5 cycles -> redirect_valid and redirect_pc stable; ack -> IDLE, br_ready=1 the next cycle.
REQ-023 flush in WAIT_DS and in REDIRECT -> IDLE next edge, redirect_valid=0; 0x10000 taken branches -> taken_cnt=0xFFFF (saturated).
REQ-024 rst_n low asynchronously mid-REDIRECT -> outputs are at reset values before the next clock edge.
